// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//   Modulo-(MAX+1) up/down counter with synchronous load, count enable and an
//   enable prescaler. Used as a timebase or event counter.
//
// Parameters
//   WIDTH     : counter width in bits (>= 1)
//   MAX       : highest count value, range is 0..MAX (1 <= MAX <= 2**WIDTH-1)
//   PRESCALE  : enabled cycles per count step (>= 1, 1 = every enabled cycle)
//   RESET_VAL : value of out after reset (<= MAX)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   en       in   count enable, advances the prescaler
//   up       in   direction, 1 = increment, 0 = decrement
//   load     in   synchronous load strobe (beats en, ignores up)
//   load_val in   value loaded on load, clamped to MAX
//   out      out  registered count value
//   tc       out  registered one-cycle terminal-count pulse
//   zero     out  combinational, high when out == 0
//
// Build option
//   COUNTER_SAT_EN : when defined, a step that would wrap holds out at MAX
//                    (up) or 0 (down) instead, still pulsing tc.
// -----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX       = 2**WIDTH - 1,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_V  = {WIDTH{1'b0}};

  logic [WIDTH-1:0] out_r;
  logic             tc_r;
  logic             step_s;
  logic [WIDTH-1:0] load_clamped_s;
  logic [WIDTH-1:0] next_out_s;
  logic             next_tc_s;

  // Prescaler: only exists when more than one enabled cycle makes a step.
  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST_V = PW'(PRESCALE - 1);
      localparam logic [PW-1:0] PONE_V = PW'(1);

      logic [PW-1:0] pre_r;

      // Step fires on the last enabled cycle of each prescale period.
      always_comb begin
        if (en && (pre_r == LAST_V)) begin
          step_s = 1'b1;
        end else begin
          step_s = 1'b0;
        end
      end

      // Prescaler phase: cleared by reset/load, held (not cleared) while en=0.
      always_ff @(posedge clk) begin
        if (rst) begin
          pre_r <= {PW{1'b0}};
        end else if (load) begin
          pre_r <= {PW{1'b0}};
        end else if (en) begin
          if (pre_r == LAST_V) begin
            pre_r <= {PW{1'b0}};
          end else begin
            pre_r <= pre_r + PONE_V;
          end
        end else begin
          pre_r <= pre_r;
        end
      end
    end else begin : g_nopre
      // Without a prescaler every enabled cycle is a step.
      always_comb begin
        step_s = en;
      end
    end
  endgenerate

  // Load values above MAX are clamped so out can never leave 0..MAX.
  always_comb begin
    if (load_val > MAX_V) begin
      load_clamped_s = MAX_V;
    end else begin
      load_clamped_s = load_val;
    end
  end

  // Next count and terminal-count for a non-load cycle.
  // Compares use >= / == so an impossible out > MAX still folds back in range.
  always_comb begin
    next_out_s = out_r;
    next_tc_s  = 1'b0;
    if (step_s) begin
      if (up) begin
        if (out_r >= MAX_V) begin
`ifdef COUNTER_SAT_EN
          next_out_s = MAX_V;
`else
          next_out_s = ZERO_V;
`endif
          next_tc_s  = 1'b1;
        end else begin
          next_out_s = out_r + ONE_V;
          next_tc_s  = 1'b0;
        end
      end else begin
        if (out_r == ZERO_V) begin
`ifdef COUNTER_SAT_EN
          next_out_s = ZERO_V;
`else
          next_out_s = MAX_V;
`endif
          next_tc_s  = 1'b1;
        end else begin
          next_out_s = out_r - ONE_V;
          next_tc_s  = 1'b0;
        end
      end
    end else begin
      next_out_s = out_r;
      next_tc_s  = 1'b0;
    end
  end

  // Count and tc registers, priority rst > load > step.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= RESET_V;
      tc_r  <= 1'b0;
    end else if (load) begin
      out_r <= load_clamped_s;
      tc_r  <= 1'b0;
    end else begin
      out_r <= next_out_s;
      tc_r  <= next_tc_s;
    end
  end

  assign out  = out_r;
  assign tc   = tc_r;
  assign zero = (out_r == ZERO_V);

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] load_val;
  logic [3:0] a_out, b_out;
  logic       a_tc, b_tc, a_zero, b_zero;
  int         total = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  // a: MAX=9, no prescaler, reset value 3
  mod_updown_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .RESET_VAL(3)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(a_out), .tc(a_tc), .zero(a_zero));

  // b: MAX=9, prescale by 3, reset value 0
  mod_updown_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3), .RESET_VAL(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(b_out), .tc(b_tc), .zero(b_zero));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0;
    tick(); tick();
    total++; if (a_out !== 4'd3) $display("FAIL reset_a_out got %0d want 3", a_out); else passed++;
    total++; if (a_tc !== 1'b0) $display("FAIL reset_a_tc got %b want 0", a_tc); else passed++;
    total++; if (a_zero !== 1'b0) $display("FAIL reset_a_zero got %b want 0", a_zero); else passed++;
    total++; if (b_out !== 4'd0) $display("FAIL reset_b_out got %0d want 0", b_out); else passed++;
    total++; if (b_zero !== 1'b1) $display("FAIL reset_b_zero got %b want 1", b_zero); else passed++;
    rst = 1'b0;
    tick();
    total++; if (a_out !== 4'd4) $display("FAIL reset_release got %0d want 4", a_out); else passed++;
  endtask

  task automatic test_wrap_up();
    en = 1'b0; load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    total++; if (a_zero !== 1'b1 || a_out !== 4'd0) $display("FAIL up_start got out=%0d zero=%b want 0/1", a_out, a_zero); else passed++;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++;
      if (a_out !== 4'(i) || a_tc !== 1'b0 || a_zero !== 1'b0)
        $display("FAIL up_count got out=%0d tc=%b zero=%b want %0d/0/0", a_out, a_tc, a_zero, i);
      else passed++;
    end
    tick();
    total++; if (a_out !== 4'd0 || a_tc !== 1'b1 || a_zero !== 1'b1) $display("FAIL up_wrap got out=%0d tc=%b zero=%b want 0/1/1", a_out, a_tc, a_zero); else passed++;
    tick();
    total++; if (a_out !== 4'd1 || a_tc !== 1'b0) $display("FAIL up_after_wrap got out=%0d tc=%b want 1/0", a_out, a_tc); else passed++;
  endtask

  task automatic test_down_dir();
    load = 1'b1; load_val = 4'd1; en = 1'b1;
    tick();
    load = 1'b0; up = 1'b0;
    total++; if (a_out !== 4'd1) $display("FAIL dn_load got %0d want 1", a_out); else passed++;
    tick();
    total++; if (a_out !== 4'd0 || a_tc !== 1'b0) $display("FAIL dn_to0 got out=%0d tc=%b want 0/0", a_out, a_tc); else passed++;
    tick();
    total++; if (a_out !== 4'd9 || a_tc !== 1'b1) $display("FAIL dn_wrap got out=%0d tc=%b want 9/1", a_out, a_tc); else passed++;
    up = 1'b1;
    tick();
    total++; if (a_out !== 4'd0 || a_tc !== 1'b1) $display("FAIL dir_wrap got out=%0d tc=%b want 0/1", a_out, a_tc); else passed++;
    tick();
    total++; if (a_out !== 4'd1 || a_tc !== 1'b0) $display("FAIL dir_next got out=%0d tc=%b want 1/0", a_out, a_tc); else passed++;
  endtask

  task automatic test_prescale();
    rst = 1'b1; load = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (b_out !== 4'(k / 3)) $display("FAIL pre_count edge %0d got %0d want %0d", k, b_out, k / 3);
      else passed++;
    end
    // phase is 1 of 3 here; pause two cycles then resume
    en = 1'b0;
    tick(); tick();
    total++; if (b_out !== 4'd2) $display("FAIL pre_hold got %0d want 2", b_out); else passed++;
    en = 1'b1;
    tick();
    total++; if (b_out !== 4'd2) $display("FAIL pre_resume1 got %0d want 2", b_out); else passed++;
    tick();
    total++; if (b_out !== 4'd3) $display("FAIL pre_resume2 got %0d want 3", b_out); else passed++;
  endtask

  task automatic test_load_prio();
    en = 1'b1; up = 1'b1;
    tick();  // put b mid-phase before the load
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    total++; if (a_out !== 4'd9 || a_tc !== 1'b0) $display("FAIL load_clamp_a got out=%0d tc=%b want 9/0", a_out, a_tc); else passed++;
    total++; if (b_out !== 4'd9) $display("FAIL load_clamp_b got %0d want 9", b_out); else passed++;
    tick(); tick();
    total++; if (b_out !== 4'd9 || b_tc !== 1'b0) $display("FAIL load_pre_clr got out=%0d tc=%b want 9/0", b_out, b_tc); else passed++;
    tick();
    total++; if (b_out !== 4'd0 || b_tc !== 1'b1) $display("FAIL load_pre_step got out=%0d tc=%b want 0/1", b_out, b_tc); else passed++;
    load = 1'b1; load_val = 4'd7; en = 1'b0;
    tick();
    total++; if (a_out !== 4'd7) $display("FAIL load_inrange got %0d want 7", a_out); else passed++;
    rst = 1'b1; load_val = 4'd5; en = 1'b1;
    tick();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    total++; if (a_out !== 4'd3 || b_out !== 4'd0) $display("FAIL rst_over_load got a=%0d b=%0d want 3/0", a_out, b_out); else passed++;
  endtask

  task automatic test_sat_or_wrap();
    load = 1'b1; load_val = 4'd8; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0;
    tick();
    total++; if (a_out !== 4'd9 || a_tc !== 1'b0) $display("FAIL edge_to_max got out=%0d tc=%b want 9/0", a_out, a_tc); else passed++;
    tick();
`ifdef COUNTER_SAT_EN
    total++; if (a_out !== 4'd9 || a_tc !== 1'b1) $display("FAIL sat_up1 got out=%0d tc=%b want 9/1", a_out, a_tc); else passed++;
    tick();
    total++; if (a_out !== 4'd9 || a_tc !== 1'b1) $display("FAIL sat_up2 got out=%0d tc=%b want 9/1", a_out, a_tc); else passed++;
`else
    total++; if (a_out !== 4'd0 || a_tc !== 1'b1) $display("FAIL wrap_up1 got out=%0d tc=%b want 0/1", a_out, a_tc); else passed++;
    tick();
    total++; if (a_out !== 4'd1 || a_tc !== 1'b0) $display("FAIL wrap_up2 got out=%0d tc=%b want 1/0", a_out, a_tc); else passed++;
`endif
    load = 1'b1; load_val = 4'd1; up = 1'b0;
    tick();
    load = 1'b0;
    tick();
    total++; if (a_out !== 4'd0 || a_tc !== 1'b0) $display("FAIL edge_to_zero got out=%0d tc=%b want 0/0", a_out, a_tc); else passed++;
    tick();
`ifdef COUNTER_SAT_EN
    total++; if (a_out !== 4'd0 || a_tc !== 1'b1) $display("FAIL sat_dn got out=%0d tc=%b want 0/1", a_out, a_tc); else passed++;
`else
    total++; if (a_out !== 4'd9 || a_tc !== 1'b1) $display("FAIL wrap_dn got out=%0d tc=%b want 9/1", a_out, a_tc); else passed++;
`endif
    en = 1'b0;
    tick();
    total++; if (a_tc !== 1'b0) $display("FAIL tc_idle got %b want 0", a_tc); else passed++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    test_reset();
    test_wrap_up();
    test_down_dir();
    test_prescale();
    test_load_prio();
    test_sat_or_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor to the team's fixed 4-bit up-counter. Generalised to WIDTH bits with a programmable modulus, up/down direction, synchronous load, count enable and an enable prescaler. It emits a terminal-count pulse and a zero flag, and is used as a timebase or event counter in playground designs. Single clock domain; no handshakes beyond level enables.

Parameters:
WIDTH, 4, counter width in bits (>=1)
MAX, 2**WIDTH-1, highest count value; range is 0..MAX (MAX <= 2**WIDTH-1, >=1)
PRESCALE, 1, number of enabled cycles per count step (>=1; 1 = step every enabled cycle)
RESET_VAL, 0, value of out after reset (must be <= MAX)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  count enable; advances prescaler when high
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
out  output  WIDTH  registered count value
tc  output  1  registered one-cycle terminal-count (wrap) pulse
zero  output  1  combinational, high when out == 0

Behaviour:
- Reset (rst=1 at clk edge): out=RESET_VAL, tc=0, prescaler=0. zero follows out.
- Priority per edge: rst > load > en. All state updates on the rising clk edge only.
- Load: out <= min(load_val, MAX); prescaler <= 0; tc <= 0. Load ignores en and up.
- Prescaler: internal count 0..PRESCALE-1, advances only when en=1 and load=0.
  - step = en & (prescaler == PRESCALE-1); on step the prescaler returns to 0.
  - en=0 holds the prescaler; it is not cleared.
  - PRESCALE=1 ties step to en; no prescaler register is needed.
- Step, up=1: out == MAX -> out <= 0, tc <= 1; else out <= out+1, tc <= 0.
- Step, down (up=0): out == 0 -> out <= MAX, tc <= 1; else out <= out-1, tc <= 0.
- No step: out holds, tc <= 0. tc is never high for two consecutive cycles unless consecutive steps both wrap (MAX=1 case excluded: see Test Plan).
- Latency: out and tc reflect a step/load one cycle after the edge that samples it (registered outputs).
- Direction change takes effect on the next step; the prescaler phase is preserved.
- Arithmetic is modulo MAX+1, not 2**WIDTH. out never exceeds MAX under any input sequence.
- Reset mid-count or mid-prescale: everything returns to reset values on that edge, and any pending step is discarded.
- Simultaneous load and en: load wins, and the prescaler is cleared.

Optional Feature:
Macro COUNTER_SAT_EN.
- Defined: saturating mode. A step that would wrap instead holds out at MAX (up) or 0 (down) and asserts tc for that cycle. Every further blocked step re-asserts tc.
- Not defined: wrap-around behaviour as above.
- Load, reset and prescaler behaviour are identical in both builds.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=3, hold rst=1 for 2 edges with en=1 -> out=3, tc=0, zero=0; release -> next edge out=4.
- Modulo wrap up: MAX=9, PRESCALE=1, en=1, up=1 from reset 0 -> out 0..9, then 0. tc=1 only in the cycle out shows 0 after 9; zero=1 at out=0.
- Down wrap and direction change: MAX=9, load 1, up=0 -> out 1,0,9 (tc=1 with 9). Set up=1 -> 9 wraps to 0 (tc=1), then 1.
- Prescaler: PRESCALE=3, en=1, up=1 from 0 -> out increments every 3rd edge (0,0,0,1,1,1,2). Drop en for 2 cycles mid-phase -> phase is resumed, not restarted.
- Load priority and clamp: MAX=9, assert load=1 with load_val=15 and en=1 -> out=9, tc=0, prescaler=0. Assert rst and load together -> out=RESET_VAL.
- COUNTER_SAT_EN build: MAX=9, up=1 from 8 -> out 9, 9, 9 with tc=1 on each blocked step. up=0 from 1 -> out 0, 0 with tc=1 on the blocked step.
